acc_fifo_writer: RTL and testbench

Producer side of the accumulator-input lane FIFOs. Accepts full-width accumulator rows over a valid/ready stream and writes each row's Y_SCALED lane slices into the Y_SCALED lane FIFOs in the same cycle. It honours per-lane almost-full backpressure. It issues a one-cycle `start_compute` pulse to the systolic reader once the first row is resident in the FIFOs, and `done` after the last row is written.

---
 rtl/acc_fifo_writer.sv | 137 +++++++++++++
 tb/tb_acc_fifo_writer.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_fifo_writer.sv
// acc_fifo_writer: streams accumulator rows into Y_SCALED lane FIFOs.
// Optional feature macro ACC_WR_TLAST_EN adds in_last for early termination.
module acc_fifo_writer #(
    parameter int Y_SCALED      = 4,
    parameter int ALPHA         = 4,
    parameter int ADD_DATAWIDTH = 16,
    parameter int CNT_W         = 16,
    localparam int W            = ALPHA * ADD_DATAWIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_load,
    input  logic [CNT_W-1:0]    row_count,
    input  logic [W-1:0]        in_data [0:Y_SCALED-1],
    input  logic                in_valid,
`ifdef ACC_WR_TLAST_EN
    input  logic                in_last,
`endif
    output logic                in_ready,
    output logic [W-1:0]        fifo_wdata [0:Y_SCALED-1],
    output logic [0:Y_SCALED-1] fifo_wr,
    input  logic [0:Y_SCALED-1] fifo_afull,
    output logic                busy,
    output logic                start_compute,
    output logic                done,
    output logic [CNT_W-1:0]    rows_written
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] row_count_q;
    logic [CNT_W-1:0] rows_accepted;
    logic             wr_q;
    logic             start_c_q;
    logic             accept;
    logic             last_row;
    logic             start_ok;

    assign accept   = in_valid && in_ready;
    assign start_ok = (state_q == IDLE) && start_load;

`ifdef ACC_WR_TLAST_EN
    assign last_row = accept &&
                      ((rows_accepted + ONE == row_count_q) || in_last);
`else
    assign last_row = accept && (rows_accepted + ONE == row_count_q);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_load) begin
                    state_d = (row_count == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (last_row) begin
                    state_d = FLUSH;
                end
            end
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            LOAD: begin
                busy     = 1'b1;
                in_ready = (rows_accepted < row_count_q) && !(|fifo_afull);
            end
            FLUSH:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // A reset drops any accepted-but-unwritten row along with the counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q          <= 1'b0;
            start_c_q     <= 1'b0;
            row_count_q   <= '0;
            rows_accepted <= '0;
            rows_written  <= '0;
            for (int i = 0; i < Y_SCALED; i++) begin
                fifo_wdata[i] <= '0;
            end
        end else begin
            wr_q      <= accept;
            start_c_q <= wr_q && (rows_written == '0);
            if (accept) begin
                for (int i = 0; i < Y_SCALED; i++) begin
                    fifo_wdata[i] <= in_data[i];
                end
            end
            if (start_ok) begin
                row_count_q   <= row_count;
                rows_accepted <= '0;
                rows_written  <= '0;
            end else begin
                if (accept) begin
                    rows_accepted <= rows_accepted + ONE;
                end
                if (wr_q) begin
                    rows_written <= rows_written + ONE;
                end
            end
        end
    end

    assign fifo_wr       = {Y_SCALED{wr_q}};
    assign start_compute = start_c_q;

endmodule

// File: tb/tb_acc_fifo_writer.sv
// tb_acc_fifo_writer: directed bench for acc_fifo_writer.
// Define ACC_WR_TLAST_EN for both files to exercise in_last.
module tb_acc_fifo_writer;

    localparam int Y  = 4;
    localparam int W  = 64;
    localparam int CW = 16;
    localparam int NL = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_load;
    logic [CW-1:0] row_count;
    logic [W-1:0]  in_data [0:Y-1];
    logic          in_valid;
`ifdef ACC_WR_TLAST_EN
    logic          in_last;
`endif
    logic          in_ready;
    logic [W-1:0]  fifo_wdata [0:Y-1];
    logic [0:Y-1]  fifo_wr;
    logic [0:Y-1]  fifo_afull;
    logic          busy;
    logic          start_compute;
    logic          done;
    logic [CW-1:0] rows_written;

    int checks = 0;
    int errors = 0;

    acc_fifo_writer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_load    (start_load),
        .row_count     (row_count),
        .in_data       (in_data),
        .in_valid      (in_valid),
`ifdef ACC_WR_TLAST_EN
        .in_last       (in_last),
`endif
        .in_ready      (in_ready),
        .fifo_wdata    (fifo_wdata),
        .fifo_wr       (fifo_wr),
        .fifo_afull    (fifo_afull),
        .busy          (busy),
        .start_compute (start_compute),
        .done          (done),
        .rows_written  (rows_written)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log, sampled mid-cycle on the falling edge.
    int           wr_cnt = 0;
    int           wr_cyc [0:NL-1];
    logic [W-1:0] wlog [0:NL-1][0:Y-1];
    int           split_cnt = 0;
    int           sc_cnt = 0;
    int           sc_cyc = 0;
    int           done_cnt = 0;
    int           done_cyc = 0;
    int           busy_cnt = 0;
    int           acc_cnt = 0;

    always @(negedge clk) begin
        if (fifo_wr != '0) begin
            if (fifo_wr != '1) split_cnt <= split_cnt + 1;
            if (wr_cnt < NL) begin
                wr_cyc[wr_cnt] <= cyc;
                for (int i = 0; i < Y; i++) wlog[wr_cnt][i] <= fifo_wdata[i];
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (start_compute) begin
            sc_cnt <= sc_cnt + 1;
            sc_cyc <= cyc;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (busy) busy_cnt <= busy_cnt + 1;
        if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
    end

    function automatic logic [W-1:0] word(int r, int i);
        logic [3:0] rr;
        logic [3:0] ii;
        rr = 4'(r);
        ii = 4'(i);
        return {4{rr, ii, rr, ii}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(int r);
        for (int i = 0; i < Y; i++) in_data[i] = word(r, i);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got rdy=%b busy=%b done=%b exp 0",
                     in_ready, busy, done);
        end
        checks++;
        if (fifo_wr !== '0 || start_compute !== 1'b0) begin
            errors++;
            $display("FAIL reset_wr got wr=%b sc=%b exp 0",
                     fifo_wr, start_compute);
        end
        checks++;
        if (rows_written !== '0) begin
            errors++;
            $display("FAIL reset_rows got %0d exp 0", rows_written);
        end
        for (int i = 0; i < Y; i++) begin
            checks++;
            if (fifo_wdata[i] !== '0) begin
                errors++;
                $display("FAIL reset_wdata[%0d] got %h exp 0", i, fifo_wdata[i]);
            end
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int bw = wr_cnt;
        int bs = sc_cnt;
        int bd = done_cnt;
        int s;
        s          = cyc;
        start_load = 1'b1;
        row_count  = 3;
        tick();
        start_load = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_load got busy=%b rdy=%b exp 1 1", busy, in_ready);
        end
        in_valid = 1'b1;
        for (int r = 0; r < 3; r++) begin
            set_row(r);
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if (wr_cnt - bw !== 3 || split_cnt !== 0) begin
            errors++;
            $display("FAIL basic_writes got %0d split %0d exp 3 0",
                     wr_cnt - bw, split_cnt);
        end
        checks++;
        if (wr_cyc[bw] !== s + 2 || wr_cyc[bw+2] !== s + 4) begin
            errors++;
            $display("FAIL basic_wr_cyc got %0d..%0d exp %0d..%0d",
                     wr_cyc[bw], wr_cyc[bw+2], s + 2, s + 4);
        end
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < Y; i++) begin
                checks++;
                if (wlog[bw+r][i] !== word(r, i)) begin
                    errors++;
                    $display("FAIL basic_data r%0d l%0d got %h exp %h",
                             r, i, wlog[bw+r][i], word(r, i));
                end
            end
        end
        checks++;
        if (sc_cnt - bs !== 1 || sc_cyc !== s + 3) begin
            errors++;
            $display("FAIL basic_sc got n=%0d c=%0d exp 1 %0d",
                     sc_cnt - bs, sc_cyc, s + 3);
        end
        checks++;
        if (done_cnt - bd !== 1 || done_cyc !== s + 5) begin
            errors++;
            $display("FAIL basic_done got n=%0d c=%0d exp 1 %0d",
                     done_cnt - bd, done_cyc, s + 5);
        end
        checks++;
        if (rows_written !== 3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_end got rows=%0d busy=%b exp 3 0",
                     rows_written, busy);
        end
    endtask

    task automatic test_backpressure();
        int bw = wr_cnt;
        int stall_rdy = 0;
        start_load = 1'b1;
        row_count  = 4;
        tick();
        start_load = 1'b0;
        in_valid   = 1'b1;
        set_row(0);
        tick();
        fifo_afull    = '0;
        fifo_afull[2] = 1'b1;
        set_row(1);
        for (int k = 0; k < 5; k++) begin
            #1;
            if (in_ready !== 1'b0) stall_rdy++;
            tick();
        end
        fifo_afull = '0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got rdy=%b exp 1", in_ready);
        end
        tick();
        set_row(2);
        tick();
        set_row(3);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if (stall_rdy !== 0) begin
            errors++;
            $display("FAIL bp_stall got %0d ready cycles exp 0", stall_rdy);
        end
        checks++;
        if (wr_cnt - bw !== 4 || split_cnt !== 0) begin
            errors++;
            $display("FAIL bp_writes got %0d split %0d exp 4 0",
                     wr_cnt - bw, split_cnt);
        end
        checks++;
        if (wr_cyc[bw+1] - wr_cyc[bw] !== 6) begin
            errors++;
            $display("FAIL bp_gap got %0d exp 6", wr_cyc[bw+1] - wr_cyc[bw]);
        end
        for (int r = 1; r < 4; r++) begin
            for (int i = 0; i < Y; i++) begin
                checks++;
                if (wlog[bw+r][i] !== word(r, i)) begin
                    errors++;
                    $display("FAIL bp_data r%0d l%0d got %h exp %h",
                             r, i, wlog[bw+r][i], word(r, i));
                end
            end
        end
        checks++;
        if (rows_written !== 4) begin
            errors++;
            $display("FAIL bp_rows got %0d exp 4", rows_written);
        end
    endtask

    task automatic test_zero_rows();
        int bw = wr_cnt;
        int bs = sc_cnt;
        int bd = done_cnt;
        int bb = busy_cnt;
        int s;
        s          = cyc;
        start_load = 1'b1;
        row_count  = 0;
        tick();
        start_load = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_s1 got done=%b busy=%b exp 1 0", done, busy);
        end
        repeat (3) tick();
        checks++;
        if (wr_cnt - bw !== 0 || sc_cnt - bs !== 0 || busy_cnt - bb !== 0) begin
            errors++;
            $display("FAIL zero_quiet got wr=%0d sc=%0d busy=%0d exp 0 0 0",
                     wr_cnt - bw, sc_cnt - bs, busy_cnt - bb);
        end
        checks++;
        if (done_cnt - bd !== 1 || done_cyc !== s + 1) begin
            errors++;
            $display("FAIL zero_done got n=%0d c=%0d exp 1 %0d",
                     done_cnt - bd, done_cyc, s + 1);
        end
        checks++;
        if (rows_written !== 0) begin
            errors++;
            $display("FAIL zero_rows got %0d exp 0", rows_written);
        end
    endtask

    task automatic test_reset_midload();
        int bw = wr_cnt;
        int bs;
        int bd;
        start_load = 1'b1;
        row_count  = 5;
        tick();
        start_load = 1'b0;
        in_valid   = 1'b1;
        set_row(0);
        tick();
        set_row(1);
        rst_n = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (fifo_wr !== '0 || busy !== 1'b0 || in_ready !== 1'b0 ||
            start_compute !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_ctrl got wr=%b busy=%b rdy=%b sc=%b done=%b exp 0",
                     fifo_wr, busy, in_ready, start_compute, done);
        end
        checks++;
        if (rows_written !== 0 || fifo_wdata[1] !== '0) begin
            errors++;
            $display("FAIL rst_mid_regs got rows=%0d wd1=%h exp 0 0",
                     rows_written, fifo_wdata[1]);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (wr_cnt - bw !== 1) begin
            errors++;
            $display("FAIL rst_mid_pending got %0d writes exp 1", wr_cnt - bw);
        end
        bw         = wr_cnt;
        bs         = sc_cnt;
        bd         = done_cnt;
        start_load = 1'b1;
        row_count  = 2;
        tick();
        start_load = 1'b0;
        in_valid   = 1'b1;
        set_row(8);
        tick();
        set_row(9);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if (wr_cnt - bw !== 2 || wlog[bw+1][3] !== word(9, 3)) begin
            errors++;
            $display("FAIL rst_mid_reload got %0d writes %h exp 2 %h",
                     wr_cnt - bw, wlog[bw+1][3], word(9, 3));
        end
        checks++;
        if (rows_written !== 2 || sc_cnt - bs !== 1 || done_cnt - bd !== 1) begin
            errors++;
            $display("FAIL rst_mid_end got rows=%0d sc=%0d done=%0d exp 2 1 1",
                     rows_written, sc_cnt - bs, done_cnt - bd);
        end
    endtask

    task automatic test_ignored();
        int bw = wr_cnt;
        int ba = acc_cnt;
        int bd = done_cnt;
        int idle_rdy = 0;
        in_valid = 1'b1;
        set_row(5);
        for (int k = 0; k < 3; k++) begin
            #1;
            if (in_ready !== 1'b0) idle_rdy++;
            tick();
        end
        checks++;
        if (idle_rdy !== 0 || acc_cnt - ba !== 0 || wr_cnt - bw !== 0) begin
            errors++;
            $display("FAIL ign_idle got rdy=%0d acc=%0d wr=%0d exp 0 0 0",
                     idle_rdy, acc_cnt - ba, wr_cnt - bw);
        end
        start_load = 1'b1;
        row_count  = 3;
        tick();
        row_count = 9;
        for (int r = 0; r < 3; r++) begin
            set_row(r);
            tick();
        end
        start_load = 1'b0;
        row_count  = 0;
        set_row(7);
        repeat (3) tick();
        in_valid = 1'b0;
        repeat (2) tick();
        checks++;
        if (acc_cnt - ba !== 3 || wr_cnt - bw !== 3) begin
            errors++;
            $display("FAIL ign_count got acc=%0d wr=%0d exp 3 3",
                     acc_cnt - ba, wr_cnt - bw);
        end
        checks++;
        if (rows_written !== 3 || done_cnt - bd !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ign_end got rows=%0d done=%0d busy=%b exp 3 1 0",
                     rows_written, done_cnt - bd, busy);
        end
    endtask

`ifdef ACC_WR_TLAST_EN
    task automatic test_tlast();
        int bw = wr_cnt;
        int bd = done_cnt;
        start_load = 1'b1;
        row_count  = 8;
        tick();
        start_load = 1'b0;
        in_valid   = 1'b1;
        for (int r = 0; r < 3; r++) begin
            set_row(r);
            in_last = (r == 2);
            tick();
        end
        in_last = 1'b0;
        repeat (3) tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (wr_cnt - bw !== 3 || rows_written !== 3) begin
            errors++;
            $display("FAIL tlast_writes got wr=%0d rows=%0d exp 3 3",
                     wr_cnt - bw, rows_written);
        end
        checks++;
        if (done_cnt - bd !== 1 || done_cyc !== wr_cyc[bw+2] + 1) begin
            errors++;
            $display("FAIL tlast_done got n=%0d c=%0d exp 1 %0d",
                     done_cnt - bd, done_cyc, wr_cyc[bw+2] + 1);
        end
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        start_load = 1'b0;
        row_count  = '0;
        in_valid   = 1'b0;
        fifo_afull = '0;
`ifdef ACC_WR_TLAST_EN
        in_last    = 1'b0;
`endif
        set_row(0);
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_rows();
        test_reset_midload();
        test_ignored();
`ifdef ACC_WR_TLAST_EN
        test_tlast();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
